// File: rtl/data_mem_wait.sv
// Byte-addressed data memory slave for the 65HE06 d_mem_* port, with configurable
// wait states, big-endian word lanes, a backdoor preload port and halt-write detection.
module data_mem_wait #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned HALT_ADDR   = 16'hFFFE,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              d_mem_assert,
  input  logic              d_mem_cmd,
  input  logic              d_mem_be0,
  input  logic              d_mem_be1,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [15:0]       d_mem_data_out,
  output logic [15:0]       d_mem_data_in,
  output logic              d_mem_rdy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              halted,
  output logic [CNT_W-1:0]  halt_cycles
);

  localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(HALT_ADDR);
  localparam logic [7:0]        WS_M1  = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state, state_nxt;
  logic [7:0]       wcnt, wcnt_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [7:0]       mem [2**ADDR_W];

  logic              accept;
  logic              word_acc;
  logic              halt_hit;
  logic [ADDR_W-1:0] even_addr;
  logic [ADDR_W-1:0] odd_addr;

  assign accept    = d_mem_assert & d_mem_rdy;
  assign word_acc  = d_mem_be0 & d_mem_be1;
  assign even_addr = {d_mem_addr[ADDR_W-1:1], 1'b0};
  assign odd_addr  = {d_mem_addr[ADDR_W-1:1], 1'b1};
  assign halt_hit  = accept & d_mem_cmd & (d_mem_addr[ADDR_W-1:1] == HALT_A[ADDR_W-1:1]);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state <= IDLE;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Dropping assert while waiting abandons the request without touching memory.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    d_mem_rdy = 1'b0;
    case (state)
      IDLE: begin
        d_mem_rdy = (WAIT_STATES == 0);
        if (d_mem_assert && (WAIT_STATES != 0)) begin
          state_nxt = WAIT;
          wcnt_nxt  = WS_M1;
        end
      end
      WAIT: begin
        d_mem_rdy = (wcnt == 8'd0);
        if (!d_mem_assert || (wcnt == 8'd0)) begin
          state_nxt = IDLE;
        end else begin
          wcnt_nxt = wcnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Core write is issued after the backdoor write so it wins on a same-byte collision.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
    if (accept && d_mem_cmd) begin
      if (word_acc) begin
        mem[even_addr] <= d_mem_data_out[15:8];
        mem[odd_addr]  <= d_mem_data_out[7:0];
      end else begin
        mem[d_mem_addr] <= d_mem_data_out[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      d_mem_data_in <= 16'h0000;
    end else if (accept && !d_mem_cmd) begin
      if (word_acc) begin
        d_mem_data_in <= {mem[even_addr], mem[odd_addr]};
      end else begin
        d_mem_data_in <= {8'h00, mem[d_mem_addr]};
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      cycle_cnt <= '0;
    end else if (cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  // Only the first halt write captures the cycle count.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      halted      <= 1'b0;
      halt_cycles <= '0;
    end else if (halt_hit && !halted) begin
      halted      <= 1'b1;
      halt_cycles <= cycle_cnt;
    end
  end

endmodule

// File: tb/tb_data_mem_wait.sv
// Self-checking bench for data_mem_wait: a zero-wait and a three-wait instance share
// clock, reset and the backdoor port; read results go through per-instance scoreboards.
module tb_data_mem_wait;

  logic        clk;
  logic        a_rst;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;

  logic        s0_assert, s0_cmd, s0_be0, s0_be1;
  logic [15:0] s0_addr, s0_wd, dout0, hc0;
  logic        rdy0, halted0;

  logic        s3_assert, s3_cmd, s3_be0, s3_be1;
  logic [15:0] s3_addr, s3_wd, dout3, hc3;
  logic        rdy3, halted3;

  int total = 0;
  int bad   = 0;

  logic [15:0] q0 [$];
  logic [15:0] q3 [$];
  logic [7:0]  mdl0 [logic [15:0]];
  logic [7:0]  mdl3 [logic [15:0]];
  logic [15:0] ref_cnt;

  data_mem_wait #(.ADDR_W(16), .WAIT_STATES(0), .HALT_ADDR(16'hFFFE), .CNT_W(16)) u0 (
    .clk(clk), .a_rst(a_rst),
    .d_mem_assert(s0_assert), .d_mem_cmd(s0_cmd), .d_mem_be0(s0_be0), .d_mem_be1(s0_be1),
    .d_mem_addr(s0_addr), .d_mem_data_out(s0_wd), .d_mem_data_in(dout0), .d_mem_rdy(rdy0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .halted(halted0), .halt_cycles(hc0)
  );

  data_mem_wait #(.ADDR_W(16), .WAIT_STATES(3), .HALT_ADDR(16'hFFFE), .CNT_W(16)) u3 (
    .clk(clk), .a_rst(a_rst),
    .d_mem_assert(s3_assert), .d_mem_cmd(s3_cmd), .d_mem_be0(s3_be0), .d_mem_be1(s3_be1),
    .d_mem_addr(s3_addr), .d_mem_data_out(s3_wd), .d_mem_data_in(dout3), .d_mem_rdy(rdy3),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .halted(halted3), .halt_cycles(hc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: value the DUT counter holds between rising edges.
  always @(posedge clk or negedge a_rst) begin
    if (!a_rst) ref_cnt <= 16'd0;
    else if (ref_cnt != 16'hFFFF) ref_cnt <= ref_cnt + 16'd1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] exp0(input logic [15:0] a, input logic word);
    if (word) return {mdl0[{a[15:1], 1'b0}], mdl0[{a[15:1], 1'b1}]};
    return {8'h00, mdl0[a]};
  endfunction

  function automatic logic [15:0] exp3(input logic [15:0] a, input logic word);
    if (word) return {mdl3[{a[15:1], 1'b0}], mdl3[{a[15:1], 1'b1}]};
    return {8'h00, mdl3[a]};
  endfunction

  // Zero-wait write: entered and left on a falling edge.
  task automatic wr0(input logic [15:0] a, input logic [15:0] d, input logic e0, input logic e1);
    s0_assert = 1'b1; s0_cmd = 1'b1; s0_be0 = e0; s0_be1 = e1; s0_addr = a; s0_wd = d;
    #1;
    total++;
    if (rdy0 !== 1'b1) begin
      bad++; $display("[TB] FAIL wr0_rdy @%h: got %b expected 1", a, rdy0);
    end
    if (e0 && e1) begin
      mdl0[{a[15:1], 1'b0}] = d[15:8];
      mdl0[{a[15:1], 1'b1}] = d[7:0];
    end else begin
      mdl0[a] = d[7:0];
    end
    @(negedge clk);
    s0_assert = 1'b0;
  endtask

  task automatic rd0(input logic [15:0] a, input logic word);
    logic [15:0] e;
    s0_assert = 1'b1; s0_cmd = 1'b0; s0_be0 = word; s0_be1 = word; s0_addr = a; s0_wd = 16'h0;
    q0.push_back(exp0(a, word));
    #1;
    total++;
    if (rdy0 !== 1'b1) begin
      bad++; $display("[TB] FAIL rd0_rdy @%h: got %b expected 1", a, rdy0);
    end
    @(negedge clk);
    s0_assert = 1'b0;
    e = q0.pop_front();
    total++;
    if (dout0 !== e) begin
      bad++; $display("[TB] FAIL rd0_data @%h: got %h expected %h", a, dout0, e);
    end
  endtask

  // Three-wait read; leaves assert high so callers can chain back-to-back requests.
  task automatic rd3(input logic [15:0] a, input logic word);
    int lows;
    logic [15:0] e;
    s3_assert = 1'b1; s3_cmd = 1'b0; s3_be0 = word; s3_be1 = word; s3_addr = a; s3_wd = 16'h0;
    q3.push_back(exp3(a, word));
    lows = 0;
    #1;
    while (rdy3 !== 1'b1 && lows < 20) begin
      lows++;
      @(negedge clk); #1;
    end
    total++;
    if (lows != 3) begin
      bad++; $display("[TB] FAIL rd3_wait @%h: got %0d low cycles expected 3", a, lows);
    end
    @(negedge clk);
    e = q3.pop_front();
    total++;
    if (dout3 !== e) begin
      bad++; $display("[TB] FAIL rd3_data @%h: got %h expected %h", a, dout3, e);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (dout0 !== 16'h0 || dout3 !== 16'h0) begin
      bad++; $display("[TB] FAIL reset_data: got %h/%h expected 0000/0000", dout0, dout3);
    end
    @(negedge clk);
    a_rst = 1'b1;
    #1;
    total++;
    if (rdy0 !== 1'b1 || rdy3 !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_rdy: got %b/%b expected 1/0", rdy0, rdy3);
    end
    total++;
    if (halted0 !== 1'b0 || hc0 !== 16'h0 || halted3 !== 1'b0 || hc3 !== 16'h0) begin
      bad++; $display("[TB] FAIL reset_halt: got %b %h %b %h expected 0 0000 0 0000", halted0, hc0, halted3, hc3);
    end
    @(negedge clk);
  endtask

  task automatic test_word;
    wr0(16'h1000, 16'hABCD, 1'b1, 1'b1);
    rd0(16'h1001, 1'b1);
    rd0(16'h1000, 1'b0);
    rd0(16'h1001, 1'b0);
  endtask

  task automatic test_byte;
    wr0(16'h2000, 16'h5566, 1'b1, 1'b1);
    wr0(16'h2001, 16'h1234, 1'b1, 1'b0);
    rd0(16'h2001, 1'b0);
    rd0(16'h2000, 1'b0);
    rd0(16'h2000, 1'b1);
    wr0(16'h2002, 16'h9977, 1'b0, 1'b0);
    rd0(16'h2002, 1'b0);
    wr0(16'h3000, 16'hBEEF, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (dout0 !== 16'h0077) begin
      bad++; $display("[TB] FAIL read_hold: got %h expected 0077", dout0);
    end
  endtask

  task automatic test_preload;
    ld_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_addr = 16'hC000 + 16'(i);
      ld_data = 8'(i);
      mdl0[ld_addr] = ld_data;
      mdl3[ld_addr] = ld_data;
      @(negedge clk);
    end
    ld_en = 1'b0;
    rd0(16'hC010, 1'b1);
    ld_en = 1'b1; ld_addr = 16'hC005; ld_data = 8'hAA;
    mdl0[16'hC005] = 8'hAA;
    mdl3[16'hC005] = 8'hAA;
    wr0(16'hC005, 16'h0055, 1'b0, 1'b1);
    ld_en = 1'b0;
    rd0(16'hC005, 1'b0);
  endtask

  task automatic test_wait;
    rd3(16'hC010, 1'b1);
    rd3(16'hC030, 1'b0);
    s3_assert = 1'b0;
    @(negedge clk);
    s3_assert = 1'b1; s3_cmd = 1'b1; s3_be0 = 1'b1; s3_be1 = 1'b1; s3_addr = 16'hC020; s3_wd = 16'hFFFF;
    #1;
    total++;
    if (rdy3 !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_rdy1: got %b expected 0", rdy3);
    end
    @(negedge clk); #1;
    total++;
    if (rdy3 !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_rdy2: got %b expected 0", rdy3);
    end
    s3_assert = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (dout3 !== 16'h0030) begin
      bad++; $display("[TB] FAIL abort_data: got %h expected 0030", dout3);
    end
    rd3(16'hC020, 1'b1);
    s3_assert = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cnt(input logic [15:0] target);
    int guard;
    guard = 0;
    while (ref_cnt != target && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (ref_cnt != target) begin
      bad++; $display("[TB] FAIL cnt_wait: got %0d expected %0d", ref_cnt, target);
    end
  endtask

  task automatic test_halt;
    @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
    a_rst = 1'b1;
    total++;
    if (halted0 !== 1'b0) begin
      bad++; $display("[TB] FAIL halt_pre: got %b expected 0", halted0);
    end
    wait_cnt(16'd42);
    wr0(16'hFFFF, 16'h1357, 1'b1, 1'b1);
    total++;
    if (halted0 !== 1'b1 || hc0 !== 16'd42) begin
      bad++; $display("[TB] FAIL halt_first: got %b %0d expected 1 42", halted0, hc0);
    end
    wait_cnt(16'd50);
    wr0(16'hFFFE, 16'h2468, 1'b1, 1'b0);
    total++;
    if (halted0 !== 1'b1 || hc0 !== 16'd42) begin
      bad++; $display("[TB] FAIL halt_second: got %b %0d expected 1 42", halted0, hc0);
    end
    rd0(16'hFFFE, 1'b1);
    total++;
    if (halted3 !== 1'b0) begin
      bad++; $display("[TB] FAIL halt_other: got %b expected 0", halted3);
    end
  endtask

  task automatic test_reset_mid_wait;
    s3_assert = 1'b1; s3_cmd = 1'b0; s3_be0 = 1'b1; s3_be1 = 1'b1; s3_addr = 16'hC040;
    repeat (2) @(negedge clk);
    #2;
    a_rst = 1'b0;
    s3_assert = 1'b0;
    #1;
    total++;
    if (halted0 !== 1'b0 || hc0 !== 16'h0) begin
      bad++; $display("[TB] FAIL rst_halt: got %b %h expected 0 0000", halted0, hc0);
    end
    total++;
    if (dout0 !== 16'h0 || dout3 !== 16'h0) begin
      bad++; $display("[TB] FAIL rst_data: got %h/%h expected 0000/0000", dout0, dout3);
    end
    total++;
    if (rdy3 !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_rdy: got %b expected 0", rdy3);
    end
    @(negedge clk);
    a_rst = 1'b1;
    rd0(16'hC010, 1'b1);
    rd3(16'hC010, 1'b1);
    s3_assert = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    a_rst = 1'b0;
    ld_en = 1'b0; ld_addr = 16'h0; ld_data = 8'h0;
    s0_assert = 1'b0; s0_cmd = 1'b0; s0_be0 = 1'b0; s0_be1 = 1'b0; s0_addr = 16'h0; s0_wd = 16'h0;
    s3_assert = 1'b0; s3_cmd = 1'b0; s3_be0 = 1'b0; s3_be1 = 1'b0; s3_addr = 16'h0; s3_wd = 16'h0;
    test_reset();
    test_word();
    test_byte();
    test_preload();
    test_wait();
    test_halt();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
